// File: rtl/mem_responder.sv
// Three-cycle CPU memory responder: ROM, WRAM (with echo), HRAM and an IE register,
// with unmapped reads returning 0xFF and simultaneous rd/wr flagged by an err pulse.
module mem_responder #(
  parameter int ROM_DEPTH  = 32768,
  parameter int WRAM_DEPTH = 8192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr_bus,
  input  logic [7:0]  data_in,
  input  logic        rd,
  input  logic        wr,
  output logic [7:0]  data_out,
  output logic        ready,
  output logic        err,
  output logic [1:0]  dbg_state
);

  // Handshake: a request (rd xor wr) is taken at the edge leaving IDLE, inputs are
  // ignored until the FSM is back in IDLE, and ready marks the single RESP cycle.
  localparam int RA_W = (ROM_DEPTH  > 1) ? $clog2(ROM_DEPTH)  : 1;
  localparam int WA_W = (WRAM_DEPTH > 1) ? $clog2(WRAM_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        is_wr_q, is_wr_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic [7:0]  ie_q, ie_d;

  logic [7:0] rom  [ROM_DEPTH];
  logic [7:0] wram [WRAM_DEPTH];
  logic [7:0] hram [127];

  logic            is_rom, is_wram, is_hram, is_ie;
  logic [RA_W-1:0] rom_idx;
  logic [WA_W-1:0] wram_idx;
  logic [6:0]      hram_idx;
  logic [7:0]      mem_rdata;
  logic            commit;

  // Echo space sits 8 KiB above WRAM, so both share the same low index bits.
  always_comb begin
    is_rom   = ~addr_q[15];
    is_wram  = (addr_q >= 16'hC000) && (addr_q <= 16'hFDFF);
    is_hram  = (addr_q >= 16'hFF80) && (addr_q <= 16'hFFFE);
    is_ie    = (addr_q == 16'hFFFF);
    rom_idx  = addr_q[RA_W-1:0];
    wram_idx = addr_q[WA_W-1:0];
    hram_idx = addr_q[6:0];
    mem_rdata = 8'hFF;
    if (is_rom)       mem_rdata = rom[rom_idx];
    else if (is_wram) mem_rdata = wram[wram_idx];
    else if (is_hram) mem_rdata = hram[hram_idx];
    else if (is_ie)   mem_rdata = ie_q;
  end

  assign commit = (state_q == ACCESS) && is_wr_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_wr_d    = is_wr_q;
    data_out_d = data_out_q;
    ie_d       = ie_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd && wr) begin
          err_d = 1'b1;
        end else if (rd || wr) begin
          state_d = ACCESS;
          addr_d  = addr_bus;
          wdata_d = data_in;
          is_wr_d = wr;
        end
      end
      ACCESS: begin
        state_d = RESP;
        ready_d = 1'b1;
        if (!is_wr_q)   data_out_d = mem_rdata;
        else if (is_ie) ie_d = wdata_q;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= 16'h0000;
      wdata_q    <= 8'h00;
      is_wr_q    <= 1'b0;
      data_out_q <= 8'hFF;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      ie_q       <= 8'h00;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      is_wr_q    <= is_wr_d;
      data_out_q <= data_out_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      ie_q       <= ie_d;
    end
  end

  // Memory contents survive reset; only an uninterrupted ACCESS commits a write.
  always_ff @(posedge clk) begin
    if (!rst && commit) begin
      if (is_wram)      wram[wram_idx] <= wdata_q;
      else if (is_hram) hram[hram_idx] <= wdata_q;
    end
  end

  assign data_out  = data_out_q;
  assign ready     = ready_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ROM_DEPTH, default 32768, number of ROM bytes mapped at 0x0000.
REQ-002 SHALL have parameter WRAM_DEPTH, default 8192, number of WRAM bytes mapped at 0xC000.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port addr_bus  input  16  CPU address, sampled with the request.
REQ-006 SHALL have port data_in  input  8  CPU write data, sampled with wr.
REQ-007 SHALL have port rd  input  1  read request, level, sampled in IDLE.
REQ-008 SHALL have port wr  input  1  write request, level, sampled in IDLE.
REQ-009 SHALL have port data_out  output  8  read data to CPU, registered.
REQ-010 SHALL have port ready  output  1  one-cycle pulse marking access completion.
REQ-011 SHALL have port err  output  1  one-cycle pulse marking an illegal request.

Function
REQ-012 SHALL implement FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on a legal request, ACCESS->RESP unconditionally, RESP->IDLE unconditionally.
REQ-013 SHALL latch addr_bus, data_in and direction on the edge that leaves IDLE; later input changes SHALL NOT affect that access.
REQ-014 SHALL ignore rd/wr while in ACCESS or RESP; a request held high SHALL be re-sampled in the IDLE cycle after RESP (one access per 3 clocks max).
REQ-015 SHALL assert ready for exactly the RESP cycle; latency from sampling edge to ready high = 2 clocks.
REQ-016 SHALL, for reads, load data_out on the ACCESS->RESP edge so it is valid while ready is high, and hold it unchanged until the next read completes (writes do not alter data_out).
REQ-017 SHALL decode: 0x0000-0x7FFF ROM (read-only); 0xC000-0xDFFF WRAM; 0xE000-0xFDFF echo of WRAM (addr minus 0x2000); 0xFF80-0xFFFE HRAM (127 bytes); 0xFFFF IE register (8 bits).
REQ-018 SHALL index ROM and WRAM modulo ROM_DEPTH and WRAM_DEPTH (low address bits), wrapping silently.
REQ-019 SHALL return 0xFF for reads of any unmapped address (0x8000-0xBFFF, 0xFE00-0xFF7F).
REQ-020 SHALL discard writes to ROM or unmapped addresses, complete them with a normal ready pulse, and not assert err.
REQ-021 SHALL treat rd and wr both high in IDLE as illegal: no state change, no memory access, err high the next cycle for one clock, ready stays low.
REQ-022 SHALL complete a write to WRAM/HRAM/IE on the ACCESS->RESP edge; a read of the same address started afterwards SHALL return the new value.
REQ-023 SHALL expose ROM, WRAM and HRAM as plain arrays the bench can preload hierarchically; memory contents SHALL NOT be cleared by rst.

Reset
REQ-024 SHALL, while rst is high at a rising edge, set state IDLE, data_out 0xFF, ready 0, err 0, IE 0x00.
REQ-025 SHALL abandon an in-flight access when rst is asserted mid-operation: no ready pulse, and a write not yet committed (in IDLE/ACCESS) SHALL NOT be committed.
REQ-026 SHALL accept a request in the first cycle after rst deasserts.

Verification
REQ-027 SHALL cover: ROM[0x0100]=0x3E preloaded, rd at 0x0100 -> ready high 2 clocks later, data_out=0x3E.
REQ-028 SHALL cover: wr 0xC123<=0x5A, then rd 0xE123 -> data_out=0x5A (echo), then rd 0xC123 -> 0x5A.
REQ-029 SHALL cover: rd 0xFEA0 -> data_out=0xFF; wr 0x2000<=0x01 then rd 0x2000 -> original ROM byte, err never high.
REQ-030 SHALL cover: rd and wr high together at 0xFF80 -> err pulse 1 clock, no ready, HRAM[0] unchanged.
REQ-031 SHALL cover: rd held high 9 clocks at 0xFFFF after wr 0xFFFF<=0x1F -> exactly 3 ready pulses, each with data_out=0x1F.
REQ-032 SHALL cover: wr 0xFF90<=0xAA, rst asserted in ACCESS -> no ready, data_out=0xFF, IE=0x00, subsequent rd 0xFF90 returns prior value.
